seg7_frame_decoder: RTL and testbench

//  Receive-side counterpart of the FRANK6000 binary-to-7-segment encoder: samples a

---
 rtl/seg7_frame_decoder.sv | 158 +++++++++++++++
 tb/tb_seg7_frame_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_frame_decoder.sv
// Samples a multiplexed 7-segment bus, captures each digit once its pattern has been
// held stable, and presents the assembled hex word on a valid/ready interface.
module seg7_frame_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_segment_A,
  input  logic                    i_segment_B,
  input  logic                    i_segment_C,
  input  logic                    i_segment_D,
  input  logic                    i_segment_E,
  input  logic                    i_segment_F,
  input  logic                    i_segment_G,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic                    i_ready,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]   o_digit_err,
  output logic                    o_valid,
  output logic                    o_overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {COLLECT, PRESENT} state_t;

  logic [6:0]              seg_p0, seg_p1;
  logic [NUM_DIGITS-1:0]   en_p0, en_p1;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic                    capture;
  logic [4:0]              dec_p0;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_err;
  logic [NUM_DIGITS-1:0]   captured;
  logic                    frame_done;
  state_t                  state_q, state_d;
  logic                    load_frame, clr_captured, set_overrun;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
  endfunction

  // Returns {illegal, nibble}; anything not in the glyph set, blank included, is illegal.
  function automatic logic [4:0] decode_glyph(input logic [6:0] p);
    case (p)
      7'h7E: return 5'h00;
      7'h30: return 5'h01;
      7'h6D: return 5'h02;
      7'h79: return 5'h03;
      7'h33: return 5'h04;
      7'h5B: return 5'h05;
      7'h5F: return 5'h06;
      7'h70: return 5'h07;
      7'h7F: return 5'h08;
      7'h7B: return 5'h09;
      7'h77: return 5'h0A;
      7'h1F: return 5'h0B;
      7'h4E: return 5'h0C;
      7'h3D: return 5'h0D;
      7'h4F: return 5'h0E;
      7'h47: return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  // Stage p0: raw bus sample; stage p1: previous sample for stability comparison
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      seg_p0 <= '0;
      en_p0  <= '0;
      seg_p1 <= '0;
      en_p1  <= '0;
      cnt    <= '0;
    end else begin
      seg_p0 <= {i_segment_A, i_segment_B, i_segment_C, i_segment_D,
                 i_segment_E, i_segment_F, i_segment_G};
      en_p0  <= i_digit_en;
      seg_p1 <= seg_p0;
      en_p1  <= en_p0;
      cnt    <= cnt_next;
    end
  end

  always_comb begin
    cnt_next = cnt;
    if (!is_onehot(en_p0))
      cnt_next = '0;
    else if ((seg_p0 != seg_p1) || (en_p0 != en_p1))
      cnt_next = CNT_W'(1);
    else if (cnt != CNT_W'(STABLE_CYCLES))
      cnt_next = cnt + CNT_W'(1);
  end

  assign capture    = (cnt == CNT_W'(STABLE_CYCLES - 1)) &&
                      (cnt_next == CNT_W'(STABLE_CYCLES));
  assign dec_p0     = decode_glyph(seg_p0);
  assign frame_done = &captured;

  // Shadow registers only reach the outputs once every digit has been rewritten
  always_ff @(posedge i_clk) begin
    if (capture) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (en_p0[d]) begin
          shadow_val[4*d +: 4] <= dec_p0[3:0];
          shadow_err[d]        <= dec_p0[4];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    load_frame   = 1'b0;
    clr_captured = 1'b0;
    set_overrun  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (frame_done) begin
          load_frame   = 1'b1;
          clr_captured = 1'b1;
          state_d      = PRESENT;
        end
      end
      PRESENT: begin
        if (frame_done) begin
          clr_captured = 1'b1;
          if (i_ready) load_frame  = 1'b1;
          else         set_overrun = 1'b1;
        end else if (i_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= COLLECT;
      captured    <= '0;
      o_value     <= '0;
      o_digit_err <= '0;
      o_overrun   <= 1'b0;
    end else begin
      state_q  <= state_d;
      captured <= (clr_captured ? '0 : captured) | (capture ? en_p0 : '0);
      if (load_frame) begin
        o_value     <= shadow_val;
        o_digit_err <= shadow_err;
      end
      if (set_overrun) o_overrun <= 1'b1;
    end
  end

  assign o_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: directed scenarios plus randomized bus traffic, all
// checked cycle by cycle against a run-length/queue reference model.
module tb_seg7_frame_decoder;
  localparam int ND = 4;
  localparam int SC = 4;
  localparam int SW = 7 + ND;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg;
  logic [ND-1:0] en;
  logic          rdy;
  logic [4*ND-1:0] o_value;
  logic [ND-1:0]   o_digit_err;
  logic            o_valid, o_overrun;

  always #5 clk = ~clk;

  seg7_frame_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_segment_A(seg[6]), .i_segment_B(seg[5]), .i_segment_C(seg[4]),
    .i_segment_D(seg[3]), .i_segment_E(seg[2]), .i_segment_F(seg[1]),
    .i_segment_G(seg[0]),
    .i_digit_en(en), .i_ready(rdy),
    .o_value(o_value), .o_digit_err(o_digit_err),
    .o_valid(o_valid), .o_overrun(o_overrun)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  logic [6:0]      glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [SW-1:0]   hist [$];
  bit              m_cap [ND];
  logic [3:0]      m_nib [ND];
  bit              m_err [ND];
  bit              m_valid, m_ovr;
  logic [4*ND-1:0] m_value;
  logic [ND-1:0]   m_derr;

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] nib, output bit bad);
    nib = 4'h0;
    bad = 1'b1;
    for (int i = 0; i < 16; i++)
      if (glyph[i] == p) begin
        nib = 4'(i);
        bad = 1'b0;
      end
  endfunction

  task automatic model_edge();
    logic [SW-1:0] s;
    bit            held, cap_now, all_cap, bad;
    logic [3:0]    nib;
    int            n;
    if (!rst_n) begin
      hist.delete();
      hist.push_back('0);
      for (int d = 0; d < ND; d++) begin
        m_cap[d] = 0; m_nib[d] = 0; m_err[d] = 0;
      end
      m_valid = 0; m_ovr = 0; m_value = '0; m_derr = '0;
      return;
    end
    // A digit is captured when its sample has been seen for exactly SC cycles
    cap_now = 0;
    s = hist[$];
    n = hist.size();
    if (n >= SC && $countones(s[ND-1:0]) == 1) begin
      held = 1;
      for (int k = 1; k < SC; k++)
        if (hist[n-1-k] != s) held = 0;
      if (held && (n == SC || hist[n-1-SC] != s)) cap_now = 1;
    end
    all_cap = 1;
    for (int d = 0; d < ND; d++) if (!m_cap[d]) all_cap = 0;
    if (all_cap) begin
      if (!m_valid || rdy) begin
        for (int d = 0; d < ND; d++) begin
          m_value[4*d +: 4] = m_nib[d];
          m_derr[d]         = m_err[d];
        end
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
      for (int d = 0; d < ND; d++) m_cap[d] = 0;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (cap_now) begin
      ref_decode(s[SW-1:ND], nib, bad);
      for (int d = 0; d < ND; d++)
        if (s[d]) begin
          m_nib[d] = nib; m_err[d] = bad; m_cap[d] = 1;
        end
    end
    hist.push_back({seg, en});
    if (hist.size() > SC + 1) void'(hist.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("valid",   32'(o_valid),     32'(m_valid));
    check_eq("value",   32'(o_value),     32'(m_value));
    check_eq("dig_err", 32'(o_digit_err), 32'(m_derr));
    check_eq("overrun", 32'(o_overrun),   32'(m_ovr));
  endtask

  task automatic drive(input logic [6:0] p, input logic [ND-1:0] e, input int n);
    seg = p;
    en  = e;
    repeat (n) step();
  endtask

  initial begin
    int r;
    rst_n = 1'b0; seg = '0; en = '0; rdy = 1'b1;
    step(); step();
    check_eq("rst_value",   32'(o_value),     32'h0);
    check_eq("rst_err",     32'(o_digit_err), 32'h0);
    check_eq("rst_valid",   32'(o_valid),     32'h0);
    check_eq("rst_overrun", 32'(o_overrun),   32'h0);
    rst_n = 1'b1;

    // Full frame with ready high
    drive(7'h5B, 4'b0001, 4); drive(7'h33, 4'b0010, 4);
    drive(7'h79, 4'b0100, 4); drive(7'h6D, 4'b1000, 4);
    drive(7'h00, 4'b0000, 1);
    check_eq("t2_early", 32'(o_valid), 32'h0);
    step();
    check_eq("t2_value", 32'(o_value), 32'h2345);
    check_eq("t2_valid", 32'(o_valid), 32'h1);
    check_eq("t2_err",   32'(o_digit_err), 32'h0);
    step();
    check_eq("t2_pulse", 32'(o_valid), 32'h0);

    // Short glitch, blank glyph, multi-hot select
    drive(7'h30, 4'b0010, 3); drive(7'h00, 4'b0000, 5);
    drive(7'h7E, 4'b0001, 4); drive(7'h00, 4'b0100, 4); drive(7'h77, 4'b1000, 4);
    drive(7'h30, 4'b0011, 10);
    check_eq("t3_no_frame", 32'(o_valid), 32'h0);
    drive(7'h30, 4'b0010, 4); drive(7'h00, 4'b0000, 2);
    check_eq("t4_value", 32'(o_value), 32'hA010);
    check_eq("t4_err",   32'(o_digit_err), 32'h4);
    check_eq("t4_valid", 32'(o_valid), 32'h1);
    drive(7'h00, 4'b0000, 2);

    // Backpressure: second frame dropped
    rdy = 1'b0;
    drive(7'h7E, 4'b0001, 4); drive(7'h30, 4'b0010, 4);
    drive(7'h6D, 4'b0100, 4); drive(7'h79, 4'b1000, 4); drive(7'h00, 4'b0000, 2);
    check_eq("t5_first", 32'(o_value), 32'h3210);
    drive(7'h33, 4'b0001, 4); drive(7'h5B, 4'b0010, 4);
    drive(7'h5F, 4'b0100, 4); drive(7'h70, 4'b1000, 4); drive(7'h00, 4'b0000, 2);
    check_eq("t5_hold",    32'(o_value),   32'h3210);
    check_eq("t5_overrun", 32'(o_overrun), 32'h1);
    check_eq("t5_held",    32'(o_valid),   32'h1);
    rdy = 1'b1;
    step();
    check_eq("t5_drop", 32'(o_valid), 32'h0);

    // Reset mid-frame
    drive(7'h7F, 4'b0001, 4); drive(7'h7B, 4'b0010, 4); drive(7'h4E, 4'b0100, 2);
    rst_n = 1'b0; seg = '0; en = '0;
    step();
    check_eq("t6_rst_ovr", 32'(o_overrun), 32'h0);
    rst_n = 1'b1;
    drive(7'h1F, 4'b0001, 4); drive(7'h3D, 4'b0010, 4);
    drive(7'h4F, 4'b0100, 4); drive(7'h47, 4'b1000, 4); drive(7'h00, 4'b0000, 2);
    check_eq("t6_value", 32'(o_value), 32'hFEDB);
    check_eq("t6_err",   32'(o_digit_err), 32'h0);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      rdy = ($urandom % 4) != 0;
      if ($urandom % 60 == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      r = $urandom % 10;
      if (r < 7)
        drive(glyph[$urandom % 16], ND'(1) << ($urandom % ND), $urandom_range(1, 7));
      else if (r == 7)
        drive(7'($urandom), ND'(1) << ($urandom % ND), $urandom_range(1, 7));
      else
        drive(7'($urandom), ND'($urandom), $urandom_range(1, 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
